// File: rtl/i2c_eeprom_slave.sv
// AT24Cxx-style I2C EEPROM slave: oversampled SCL/SDA, byte/page write, current/random/sequential read,
// and an emulated write-cycle busy window during which the control byte is NACKed.
module i2c_eeprom_slave #(
    parameter int          MEM_AW     = 13,
    parameter int          ADDR_BYTES = 2,
    parameter int          PAGE_SIZE  = 32,
    parameter logic [2:0]  CHIP_SEL   = 3'b000,
    parameter int          TWR_CYCLES = 5000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy,
    output logic [MEM_AW-1:0] cur_addr,
    output logic              wr_evt
);

    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);
    localparam int                TMR_W     = $clog2(TWR_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TWR_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, CTRL, ACK_CTRL, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WDATA, ACK_WD, RDATA, MACK, WAIT_STOP
    } state_t;

    // Increment only inside the current page; the page-select bits are held.
    function automatic logic [MEM_AW-1:0] page_inc(input logic [MEM_AW-1:0] a);
        page_inc = (a & ~PAGE_MASK) | ((a + MEM_AW'(1)) & PAGE_MASK);
    endfunction

    logic              scl_s1_q, scl_s2_q, scl_dl_q;
    logic              sda_s1_q, sda_s2_q, sda_dl_q;
    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        addr_h_q, addr_h_d;
    logic              wrote_q, wrote_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [MEM_AW-1:0] cur_addr_q, cur_addr_d;
    logic              wr_evt_q, wr_evt_d;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem [2**MEM_AW];

    logic              scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
    logic              ctrl_match_s, mem_we_s;
    logic [7:0]        mem_wdata_s;
    logic [2:0]        rd_idx_s;
    logic [15:0]       addr_full_s;

    assign sda_s        = sda_s2_q;
    assign scl_rise_s   = scl_s2_q & ~scl_dl_q;
    assign scl_fall_s   = ~scl_s2_q & scl_dl_q;
    assign start_s      = scl_s2_q & scl_dl_q & sda_dl_q & ~sda_s2_q;
    assign stop_s       = scl_s2_q & scl_dl_q & ~sda_dl_q & sda_s2_q;
    assign ctrl_match_s = (shift_q[7:4] == 4'b1010) && (shift_q[3:1] == CHIP_SEL) && !busy_q;
    assign mem_wdata_s  = {shift_q[6:0], sda_s};
    assign rd_idx_s     = 3'd7 - bit_cnt_q[2:0];
    assign addr_full_s  = (ADDR_BYTES == 1) ? {8'h00, shift_q} : {addr_h_q, shift_q};

    // Synchronise the pads (idle-high) and keep one delayed copy for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_dl_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_dl_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_in;
            scl_s2_q <= scl_s1_q;
            scl_dl_q <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_dl_q <= sda_s2_q;
        end
    end

    // Protocol FSM, busy timer and address pointer next-state logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_h_d   = addr_h_q;
        wrote_d    = wrote_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        tmr_d      = tmr_q;
        cur_addr_d = cur_addr_q;
        wr_evt_d   = 1'b0;
        mem_we_s   = 1'b0;

        if (busy_q) begin
            if (tmr_q == '0) begin
                busy_d = 1'b0;
            end else begin
                tmr_d = tmr_q - TMR_W'(1);
            end
        end else begin
            tmr_d = '0;
        end

        if (start_s) begin
            state_d   = CTRL;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            wrote_d   = 1'b0;
        end else if (stop_s) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            if (wrote_q) begin
                busy_d  = 1'b1;
                tmr_d   = TMR_LOAD;
                wrote_d = 1'b0;
            end else begin
                wrote_d = 1'b0;
            end
        end else begin
            case (state_q)
                CTRL, ADDR_H, ADDR_L, WDATA: begin
                    if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Data byte commits on its 8th rise, before the ACK slot.
                        if ((state_q == WDATA) && (bit_cnt_q == 4'd7)) begin
                            mem_we_s   = 1'b1;
                            wr_evt_d   = 1'b1;
                            wrote_d    = 1'b1;
                            cur_addr_d = page_inc(cur_addr_q);
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            CTRL: begin
                                if (ctrl_match_s) begin
                                    sda_oe_d = 1'b1;
                                    state_d  = ACK_CTRL;
                                end else begin
                                    state_d  = WAIT_STOP;
                                end
                            end
                            ADDR_H: begin
                                addr_h_d = shift_q;
                                sda_oe_d = 1'b1;
                                state_d  = ACK_AH;
                            end
                            ADDR_L: begin
                                cur_addr_d = MEM_AW'(addr_full_s);
                                sda_oe_d   = 1'b1;
                                state_d    = ACK_AL;
                            end
                            default: begin
                                sda_oe_d = 1'b1;
                                state_d  = ACK_WD;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                ACK_CTRL: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            sda_oe_d = ~rd_data_q[7];
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = (ADDR_BYTES == 1) ? ADDR_L : ADDR_H;
                        end
                    end else begin
                        state_d = ACK_CTRL;
                    end
                end
                ACK_AH: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                        state_d  = ADDR_L;
                    end else begin
                        state_d  = ACK_AH;
                    end
                end
                ACK_AL, ACK_WD: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                    end else begin
                        state_d  = state_q;
                    end
                end
                RDATA: begin
                    if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = MACK;
                        end else begin
                            sda_oe_d  = ~rd_data_q[rd_idx_s];
                        end
                    end else begin
                        state_d = RDATA;
                    end
                end
                MACK: begin
                    // Read pointer wraps over the whole array, unlike page writes.
                    if (scl_rise_s) begin
                        cur_addr_d = cur_addr_q + MEM_AW'(1);
                        bit_cnt_d  = 4'd0;
                        state_d    = sda_s ? WAIT_STOP : RDATA;
                    end else begin
                        state_d    = MACK;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_d = state_q;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            addr_h_q   <= 8'h00;
            wrote_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            tmr_q      <= '0;
            cur_addr_q <= '0;
            wr_evt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_h_q   <= addr_h_d;
            wrote_q    <= wrote_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            tmr_q      <= tmr_d;
            cur_addr_q <= cur_addr_d;
            wr_evt_q   <= wr_evt_d;
        end
    end

    // Byte-wide RAM with registered read of the current pointer.
    always_ff @(posedge sys_clk) begin
        if (mem_we_s) begin
            mem[cur_addr_q] <= mem_wdata_s;
        end
        rd_data_q <= mem[cur_addr_q];
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign cur_addr = cur_addr_q;
    assign wr_evt   = wr_evt_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master on an open-drain bus model.
module tb_i2c_eeprom_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic        busy;
    logic [12:0] cur_addr;
    logic        wr_evt;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_eeprom_slave dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .cur_addr(cur_addr),
        .wr_evt  (wr_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_evt) wr_cnt = wr_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(10);
        scl = 1'b1;   cyc(10);
        sda_m = 1'b0; cyc(10);
        scl = 1'b0;   cyc(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(10);
        scl = 1'b1;   cyc(10);
        sda_m = 1'b1; cyc(20);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; cyc(10);
            scl = 1'b1;   cyc(20);
            scl = 1'b0;   cyc(10);
        end
        sda_m = 1'b1; cyc(10);
        scl = 1'b1;   cyc(10);
        ack = sda_line; cyc(10);
        scl = 1'b0;   cyc(10);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(10);
            scl = 1'b1; cyc(10);
            d = {d[6:0], sda_line}; cyc(10);
            scl = 1'b0; cyc(10);
        end
        sda_m = nack; cyc(10);
        scl = 1'b1;   cyc(20);
        scl = 1'b0;   cyc(5);
        sda_m = 1'b1; cyc(5);
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Random-read setup: A0, two address bytes, repeated START, A1.
    task automatic set_read(input logic [15:0] a, input string tag);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);    check({tag, "_c0"}, {31'd0, ack}, 32'd0);
        write_byte(a[15:8], ack);  check({tag, "_ah"}, {31'd0, ack}, 32'd0);
        write_byte(a[7:0], ack);   check({tag, "_al"}, {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'hA1, ack);    check({tag, "_c1"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         w0, b0;

        cyc(5);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cur_addr", {19'd0, cur_addr}, 32'd0);
        check("rst_wr_evt", {31'd0, wr_evt}, 32'd0);
        rst = 1'b0;
        cyc(5);

        // Byte write 0x0010 = 5A, then busy window and ACK polling.
        w0 = wr_cnt; b0 = busy_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("bw_ack_ctrl", {31'd0, ack}, 32'd0);
        write_byte(8'h00, ack); check("bw_ack_ah", {31'd0, ack}, 32'd0);
        write_byte(8'h10, ack); check("bw_ack_al", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); check("bw_ack_wd", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("bw_wr_evt", wr_cnt - w0, 32'd1);
        check("bw_cur_addr", {19'd0, cur_addr}, 32'h0011);
        check("bw_busy_set", {31'd0, busy}, 32'd1);
        i2c_start();
        write_byte(8'hA0, ack); check("poll_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        wait_not_busy("bw_busy_timeout");
        check("bw_busy_len", busy_cnt - b0, 32'd5000);
        i2c_start();
        write_byte(8'hA0, ack); check("poll_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        cyc(5);
        check("poll_no_busy", {31'd0, busy}, 32'd0);

        // Page write across the page boundary.
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h1E, ack);
        write_byte(8'h11, ack); check("pw_ack1", {31'd0, ack}, 32'd0);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack);
        write_byte(8'h44, ack); check("pw_ack4", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("pw_wr_evt", wr_cnt - w0, 32'd4);
        check("pw_cur_addr", {19'd0, cur_addr}, 32'h0002);
        wait_not_busy("pw_busy_timeout");

        // Last array byte, page-wrapped pointer afterwards.
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h1F, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hC3, ack); check("top_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("top_cur_addr", {19'd0, cur_addr}, 32'h1FE0);
        wait_not_busy("top_busy_timeout");

        // Random read of 0x0010.
        set_read(16'h0010, "rr");
        read_byte(1'b1, d); check("rr_data", {24'd0, d}, 32'h5A);
        i2c_stop();
        check("rr_cur_addr", {19'd0, cur_addr}, 32'h0011);
        cyc(5);
        check("rr_no_busy", {31'd0, busy}, 32'd0);

        // Sequential read wrapping at the array end.
        set_read(16'h1FFF, "sr");
        read_byte(1'b0, d); check("sr_d0", {24'd0, d}, 32'hC3);
        read_byte(1'b0, d); check("sr_d1", {24'd0, d}, 32'h33);
        read_byte(1'b1, d); check("sr_d2", {24'd0, d}, 32'h44);
        i2c_stop();
        check("sr_cur_addr", {19'd0, cur_addr}, 32'h0002);

        // Wrong chip select: NACK, nothing written.
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("cs_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h00, ack);
        write_byte(8'h10, ack);
        write_byte(8'h77, ack); check("cs_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("cs_wr_evt", wr_cnt - w0, 32'd0);
        check("cs_cur_addr", {19'd0, cur_addr}, 32'h0002);
        cyc(5);
        check("cs_no_busy", {31'd0, busy}, 32'd0);
        set_read(16'h0010, "cs_rd");
        read_byte(1'b1, d); check("cs_mem_kept", {24'd0, d}, 32'h5A);
        i2c_stop();

        // Current-address read continues after a random read.
        set_read(16'h001E, "ca_set");
        read_byte(1'b1, d); check("ca_d0", {24'd0, d}, 32'h11);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, ack); check("ca_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, d); check("ca_d1", {24'd0, d}, 32'h22);
        i2c_stop();
        check("ca_cur_addr", {19'd0, cur_addr}, 32'h0020);

        // Reset while the slave drives a 0 data bit.
        set_read(16'h001E, "mr");
        check("mr_driving", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("mr_sda_rel", {31'd0, sda_oe}, 32'd0);
        check("mr_cur_addr", {19'd0, cur_addr}, 32'd0);
        cyc(3);
        rst = 1'b0;
        cyc(3);
        i2c_stop();
        set_read(16'h001F, "mr_after");
        read_byte(1'b1, d); check("mr_after_d", {24'd0, d}, 32'h22);
        i2c_stop();
        check("mr_after_cur_addr", {19'd0, cur_addr}, 32'h0020);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
